// File: rtl/onehot_grant_decoder_if.sv
// Grant-bus handshake between the priority encoder side and the grant decoder.
// The decoder takes the slave modport; the encoder/testbench side takes master.
interface onehot_grant_decoder_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] grant;
    logic             idle;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_err;

    modport master (
        output in_valid, grant, idle, out_ready,
        input  in_ready, out_valid, out_idx, out_err
    );

    modport slave (
        input  in_valid, grant, idle, out_ready,
        output in_ready, out_valid, out_idx, out_err
    );
endinterface

// File: rtl/onehot_grant_decoder.sv
// One-hot grant to binary index decoder with a 2-entry result FIFO and
// illegal-beat tracking (sticky flag plus saturating counter).
module onehot_grant_decoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    onehot_grant_decoder_if.slave bus,
    input  logic       err_clr,
    output logic       err_sticky,
    output logic [7:0] err_count
);
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             err;
    } entry_t;

    entry_t [1:0]     mem;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic [IDX_W:0]   ones;
    logic [IDX_W-1:0] hi_idx;
    logic             idle_beat, legal, accept, push, pop;

    // Bit count plus highest set position; for a legal beat they coincide.
    always_comb begin
        ones   = '0;
        hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.grant[i]) begin
                ones   = ones + (IDX_W+1)'(1);
                hi_idx = i[IDX_W-1:0];
            end
        end
    end

    assign idle_beat = bus.idle && (ones == '0);
    assign legal     = !bus.idle && (ones == (IDX_W+1)'(1));

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_idx   = mem[rd_ptr].idx;
    assign bus.out_err   = mem[rd_ptr].err;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !idle_beat;
    assign pop    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem        <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{idx: hi_idx, err: !legal};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push && !pop)
                count <= count + 2'd1;
            else if (!push && pop)
                count <= count - 2'd1;
            // An illegal push outranks a same-cycle clear.
            if (push && !legal)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;
            if (push && !legal && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Randomized plus directed bench for onehot_grant_decoder against a queue-based
// behavioural model; outputs compared every falling edge.
module tb_onehot_grant_decoder;
    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       err_clr;
    logic       err_sticky;
    logic [7:0] err_count;

    onehot_grant_decoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    onehot_grant_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of results, a sticky bit, an integer count.
    typedef struct {
        int idx;
        bit err;
    } ent_t;

    ent_t m_q[$];
    bit   m_sticky;
    int   m_cnt;

    function automatic int highest_bit(input logic [WIDTH-1:0] g);
        int h = 0;
        for (int i = 0; i < WIDTH; i++)
            if (g[i]) h = i;
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_sticky = 0;
            m_cnt    = 0;
        end else begin
            bit   acc, do_pop, is_idle, is_legal;
            ent_t e;
            acc      = bus.in_valid && (m_q.size() < 2);
            do_pop   = (m_q.size() > 0) && bus.out_ready;
            is_idle  = bus.idle && (bus.grant == '0);
            is_legal = !bus.idle && ($countones(bus.grant) == 1);
            if (do_pop) void'(m_q.pop_front());
            if (err_clr) m_sticky = 0;
            if (acc && !is_idle) begin
                e.idx = highest_bit(bus.grant);
                e.err = !is_legal;
                m_q.push_back(e);
                if (!is_legal) begin
                    m_sticky = 1;
                    m_cnt    = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(bus.in_ready), int'(m_q.size() < 2));
        chk("out_valid", int'(bus.out_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("out_idx", int'(bus.out_idx), m_q[0].idx);
            chk("out_err", int'(bus.out_err), int'(m_q[0].err));
        end
        chk("err_sticky", int'(err_sticky), int'(m_sticky));
        chk("err_count", int'(err_count), m_cnt);
    end

    // Apply inputs, let one rising edge consume them, return just after it.
    task automatic cyc(input bit v, input logic [7:0] g, input bit id,
                       input bit ordy, input bit clr);
        bus.in_valid  = v;
        bus.grant     = g;
        bus.idle      = id;
        bus.out_ready = ordy;
        err_clr       = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 0; bus.grant = '0; bus.idle = 0; bus.out_ready = 0; err_clr = 0;
        #7;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_err_count", int'(err_count), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single legal beat, then drained
        cyc(1, 8'h20, 0, 1, 0);
        chk("t1_valid", int'(bus.out_valid), 1);
        chk("t1_idx", int'(bus.out_idx), 5);
        chk("t1_err", int'(bus.out_err), 0);
        cyc(0, 8'h00, 0, 1, 0);
        chk("t1_empty", int'(bus.out_valid), 0);

        // Idle beat is consumed silently
        cyc(1, 8'h00, 1, 1, 0);
        chk("t2_in_ready", int'(bus.in_ready), 1);
        chk("t2_valid", int'(bus.out_valid), 0);
        chk("t2_cnt", int'(err_count), 0);

        // Multi-hot beat, then clear sticky
        cyc(1, 8'h41, 0, 1, 0);
        chk("t3_idx", int'(bus.out_idx), 6);
        chk("t3_err", int'(bus.out_err), 1);
        chk("t3_sticky", int'(err_sticky), 1);
        chk("t3_cnt", int'(err_count), 1);
        cyc(0, 8'h00, 0, 1, 1);
        chk("t3_clr_sticky", int'(err_sticky), 0);
        chk("t3_clr_cnt", int'(err_count), 1);

        // Fill with back-pressure, third beat held off
        cyc(1, 8'h01, 0, 0, 0);
        chk("t4_rdy1", int'(bus.in_ready), 1);
        cyc(1, 8'h80, 0, 0, 0);
        chk("t4_rdy2", int'(bus.in_ready), 0);
        chk("t4_head0", int'(bus.out_idx), 0);
        cyc(1, 8'h04, 0, 0, 0);
        chk("t4_held", int'(bus.in_ready), 0);
        cyc(1, 8'h04, 0, 1, 0);
        chk("t4_head7", int'(bus.out_idx), 7);
        cyc(1, 8'h04, 0, 1, 0);
        chk("t4_head2", int'(bus.out_idx), 2);
        chk("t4_valid", int'(bus.out_valid), 1);
        cyc(0, 8'h00, 0, 1, 0);
        chk("t4_empty", int'(bus.out_valid), 0);

        // Push with pop at count 1
        cyc(1, 8'h08, 0, 0, 0);
        chk("t5_head3", int'(bus.out_idx), 3);
        cyc(1, 8'h02, 0, 1, 0);
        chk("t5_valid", int'(bus.out_valid), 1);
        chk("t5_rdy", int'(bus.in_ready), 1);
        chk("t5_head1", int'(bus.out_idx), 1);
        cyc(0, 8'h00, 0, 1, 0);

        // Saturation then mid-burst async reset
        for (int i = 0; i < 256; i++) cyc(1, 8'hC0, 0, 1, 0);
        chk("t6_sat", int'(err_count), 255);
        cyc(1, 8'h00, 0, 1, 0);
        chk("t6_sat_hold", int'(err_count), 255);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(bus.out_valid), 0);
        chk("t6_rst_cnt", int'(err_count), 0);
        chk("t6_rst_sticky", int'(err_sticky), 0);
        chk("t6_rst_rdy", int'(bus.in_ready), 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(1, 8'h10, 0, 0, 0);
        chk("t6_fresh_valid", int'(bus.out_valid), 1);
        chk("t6_fresh_idx", int'(bus.out_idx), 4);
        cyc(0, 8'h00, 0, 1, 0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] g;
            bit         id;
            int         k = $urandom_range(7);
            case ($urandom_range(5))
                0, 1, 2: begin g = 8'(1 << k); id = 0; end
                3:       begin g = 8'h00; id = 1; end
                4:       begin g = 8'h00; id = 0; end
                default: begin g = 8'($urandom); id = 1'($urandom); end
            endcase
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_valid", int'(bus.out_valid), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(1'($urandom_range(3) != 0), g, id, 1'($urandom_range(2) != 0),
                $urandom_range(9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
